data_mem_responder: RTL and testbench



---
 rtl/data_mem_responder.sv | 192 +++++++++++++++++++
 tb/tb_data_mem_responder.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - data-memory responder with configurable read/write wait states
//
// Purpose: serves load/store requests from the core's MEM stage out of a
// word-organised array. It takes one request at a time and answers a fixed
// number of cycles after accepting it.
//
// Ports:
//   Clk        - clock, rising edge
//   Rst        - asynchronous active-low reset
//   req_valid  - request present
//   req_ready  - responder can accept a request (registered, high only in IDLE)
//   req_write  - 1 = store, 0 = load
//   req_addr   - byte address
//   req_size   - 00 word, 01 halfword, 10 byte, 11 reserved
//   req_wdata  - store data, right-justified
//   rsp_valid  - response present, held until rsp_ready
//   rsp_ready  - core accepts the response
//   rsp_rdata  - full aligned word for loads; 0 for stores and errors
//   rsp_err    - misaligned, reserved size or out-of-range request
module data_mem_responder #(
  parameter int DEPTH_WORDS   = 1024,
  parameter int READ_LATENCY  = 2,
  parameter int WRITE_LATENCY = 1
) (
  input  logic        Clk,
  input  logic        Rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [1:0]  req_size,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam int CNT_W = 16;
  localparam logic [29:0] DEPTH_LIM = 30'(DEPTH_WORDS);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t           state;
  logic [CNT_W-1:0] waitCnt;
  logic             capWrite;
  logic [IDX_W-1:0] capIdx;
  logic [1:0]       capLane;
  logic [1:0]       capSize;
  logic [31:0]      capWdata;
  logic             capErr;

  logic [31:0] memArray [DEPTH_WORDS];

  logic             reqErr;
  logic             accept;
  logic             reqLat1;
  logic             waitDone;
  logic             respond;
  logic             entWrite;
  logic [IDX_W-1:0] entIdx;
  logic [1:0]       entLane;
  logic [1:0]       entSize;
  logic [31:0]      entWdata;
  logic             entErr;
  logic [31:0]      mergedWord;
  logic [31:0]      rdEntry;
  logic             memWe;

  always_comb begin
    reqErr = (req_size == 2'b11) ||
             (req_size == 2'b01 && req_addr[0]) ||
             (req_size == 2'b00 && req_addr[1:0] != 2'b00) ||
             (req_addr[31:2] >= DEPTH_LIM);
  end

  assign accept   = (state == IDLE) && req_ready && req_valid;
  assign reqLat1  = req_write ? (WRITE_LATENCY == 1) : (READ_LATENCY == 1);
  assign waitDone = (state == WAIT) && (waitCnt == CNT_W'(1));
  // The response entry edge is either the acceptance edge itself (latency 1)
  // or the last WAIT edge.
  assign respond  = (accept && reqLat1) || waitDone;

  // A latency-1 request completes on its acceptance edge, before anything has
  // been captured, so the live request feeds the datapath while in IDLE.
  always_comb begin
    if (state == IDLE) begin
      entWrite = req_write;
      entIdx   = req_addr[IDX_W+1:2];
      entLane  = req_addr[1:0];
      entSize  = req_size;
      entWdata = req_wdata;
      entErr   = reqErr;
    end else begin
      entWrite = capWrite;
      entIdx   = capIdx;
      entLane  = capLane;
      entSize  = capSize;
      entWdata = capWdata;
      entErr   = capErr;
    end
  end

  // Read-modify-write merge of the store into the addressed word.
  always_comb begin
    mergedWord = memArray[entIdx];
    case (entSize)
      2'b00: mergedWord = entWdata;
      2'b01: begin
        if (entLane[1]) mergedWord[31:16] = entWdata[15:0];
        else            mergedWord[15:0]  = entWdata[15:0];
      end
      2'b10: mergedWord[{entLane, 3'b000} +: 8] = entWdata[7:0];
      default: ;
    endcase
  end

  assign rdEntry = (!entWrite && !entErr) ? memArray[entIdx] : 32'h0;
  // Gating with Rst keeps an abandoned store from landing on a reset edge.
  assign memWe   = Rst && respond && entWrite && !entErr;

  always_ff @(posedge Clk) begin
    if (memWe) memArray[entIdx] <= mergedWord;
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= IDLE;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
      waitCnt   <= '0;
      capWrite  <= 1'b0;
      capIdx    <= '0;
      capLane   <= 2'b00;
      capSize   <= 2'b00;
      capWdata  <= 32'h0;
      capErr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          req_ready <= 1'b1;
          if (accept) begin
            req_ready <= 1'b0;
            capWrite  <= req_write;
            capIdx    <= req_addr[IDX_W+1:2];
            capLane   <= req_addr[1:0];
            capSize   <= req_size;
            capWdata  <= req_wdata;
            capErr    <= reqErr;
            waitCnt   <= req_write ? CNT_W'(WRITE_LATENCY - 1) : CNT_W'(READ_LATENCY - 1);
            if (reqLat1) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= rdEntry;
              rsp_err   <= reqErr;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          req_ready <= 1'b0;
          waitCnt   <= waitCnt - CNT_W'(1);
          if (waitDone) begin
            state     <= RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= rdEntry;
            rsp_err   <= capErr;
          end
        end
        RESP: begin
          req_ready <= 1'b0;
          if (rsp_ready) begin
            state     <= IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

  logic        Clk;
  logic        rstN [3];
  logic        rv   [3];
  logic        rw   [3];
  logic [31:0] ra   [3];
  logic [1:0]  rs   [3];
  logic [31:0] wd   [3];
  logic        rr   [3];
  logic        rdy  [3];
  logic        vld  [3];
  logic [31:0] rd   [3];
  logic        er   [3];

  int checks = 0;
  int errors = 0;

  logic [31:0] mdl [3][1024];

  // instance 0: 2/1, instance 1: 4/3, instance 2: 1/1
  data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(2), .WRITE_LATENCY(1)) dut0 (
    .Clk(Clk), .Rst(rstN[0]), .req_valid(rv[0]), .req_ready(rdy[0]), .req_write(rw[0]),
    .req_addr(ra[0]), .req_size(rs[0]), .req_wdata(wd[0]), .rsp_valid(vld[0]),
    .rsp_ready(rr[0]), .rsp_rdata(rd[0]), .rsp_err(er[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(4), .WRITE_LATENCY(3)) dut1 (
    .Clk(Clk), .Rst(rstN[1]), .req_valid(rv[1]), .req_ready(rdy[1]), .req_write(rw[1]),
    .req_addr(ra[1]), .req_size(rs[1]), .req_wdata(wd[1]), .rsp_valid(vld[1]),
    .rsp_ready(rr[1]), .rsp_rdata(rd[1]), .rsp_err(er[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .READ_LATENCY(1), .WRITE_LATENCY(1)) dut2 (
    .Clk(Clk), .Rst(rstN[2]), .req_valid(rv[2]), .req_ready(rdy[2]), .req_write(rw[2]),
    .req_addr(ra[2]), .req_size(rs[2]), .req_wdata(wd[2]), .rsp_valid(vld[2]),
    .rsp_ready(rr[2]), .rsp_rdata(rd[2]), .rsp_err(er[2]));

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #2000000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1, "global timeout");
  end

  typedef struct {
    bit          w;
    logic [31:0] a;
    logic [1:0]  s;
    logic [31:0] wdt;
    logic [31:0] expRd;
    bit          expErr;
  } vec_t;

  vec_t tbl [11];

  function automatic int latOf(input int d, input bit w);
    int rl [3] = '{2, 4, 1};
    int wl [3] = '{1, 3, 1};
    return w ? wl[d] : rl[d];
  endfunction

  function automatic bit modelErr(input logic [31:0] a, input logic [1:0] s);
    if (s == 2'd3) return 1'b1;
    if (s == 2'd1 && (a % 2) != 0) return 1'b1;
    if (s == 2'd0 && (a % 4) != 0) return 1'b1;
    if ((a / 4) >= 1024) return 1'b1;
    return 1'b0;
  endfunction

  task automatic modelStore(input int d, input logic [31:0] a, input logic [1:0] s, input logic [31:0] wdt);
    int wi, lane, nBytes;
    logic [31:0] w;
    wi = int'(a / 4);
    lane = int'(a % 4);
    nBytes = (s == 2'd0) ? 4 : (s == 2'd1) ? 2 : 1;
    if (s == 2'd0) lane = 0;
    w = mdl[d][wi];
    for (int k = 0; k < nBytes; k++) w[8*(lane+k) +: 8] = wdt[8*k +: 8];
    mdl[d][wi] = w;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic transact(input int d, input bit w, input logic [31:0] a, input logic [1:0] s,
                          input logic [31:0] wdt, output logic [31:0] rdat, output logic err,
                          output int lat);
    int guard;
    @(negedge Clk);
    rv[d] = 1'b1; rw[d] = w; ra[d] = a; rs[d] = s; wd[d] = wdt; rr[d] = 1'b1;
    guard = 0;
    while (rdy[d] !== 1'b1 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    if (guard >= 100) chk("accept_timeout", 32'(guard), 32'd0);
    @(negedge Clk);
    rv[d] = 1'b0;
    lat = 1;
    while (vld[d] !== 1'b1 && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    rdat = rd[d];
    err  = er[d];
  endtask

  task automatic runOp(input int d, input bit w, input logic [31:0] a, input logic [1:0] s,
                       input logic [31:0] wdt);
    logic [31:0] rdat, expRd;
    logic        err;
    bit          expErr;
    int          lat;
    expErr = modelErr(a, s);
    expRd  = (w || expErr) ? 32'h0 : mdl[d][int'(a / 4)];
    transact(d, w, a, s, wdt, rdat, err, lat);
    chk($sformatf("rdata d%0d a%h", d, a), rdat, expRd);
    chk($sformatf("err d%0d a%h", d, a), 32'(err), 32'(expErr));
    chk($sformatf("lat d%0d a%h", d, a), 32'(lat), 32'(latOf(d, w)));
    if (w && !expErr) modelStore(d, a, s, wdt);
  endtask

  initial begin
    logic [31:0] rdat;
    logic        err;
    int          lat, guard;
    logic [31:0] a;

    tbl[0]  = '{1'b1, 32'h10,   2'b00, 32'hDEADBEEF, 32'h0,        1'b0};
    tbl[1]  = '{1'b0, 32'h10,   2'b00, 32'h0,        32'hDEADBEEF, 1'b0};
    tbl[2]  = '{1'b1, 32'h20,   2'b00, 32'h11223344, 32'h0,        1'b0};
    tbl[3]  = '{1'b1, 32'h21,   2'b10, 32'h000000AA, 32'h0,        1'b0};
    tbl[4]  = '{1'b1, 32'h22,   2'b01, 32'h0000BEEF, 32'h0,        1'b0};
    tbl[5]  = '{1'b0, 32'h20,   2'b00, 32'h0,        32'hBEEFAA44, 1'b0};
    tbl[6]  = '{1'b1, 32'h23,   2'b01, 32'h00001234, 32'h0,        1'b1};
    tbl[7]  = '{1'b0, 32'h26,   2'b00, 32'h0,        32'h0,        1'b1};
    tbl[8]  = '{1'b0, 32'h1000, 2'b00, 32'h0,        32'h0,        1'b1};
    tbl[9]  = '{1'b1, 32'h20,   2'b11, 32'hFFFFFFFF, 32'h0,        1'b1};
    tbl[10] = '{1'b0, 32'h21,   2'b10, 32'h0,        32'hBEEFAA44, 1'b0};

    for (int d = 0; d < 3; d++) begin
      rstN[d] = 1'b0; rv[d] = 1'b0; rw[d] = 1'b0; ra[d] = 32'h0;
      rs[d] = 2'b00; wd[d] = 32'h0; rr[d] = 1'b0;
    end
    repeat (3) @(negedge Clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset_ready d%0d", d), 32'(rdy[d]), 32'd0);
      chk($sformatf("reset_valid d%0d", d), 32'(vld[d]), 32'd0);
      chk($sformatf("reset_rdata d%0d", d), rd[d], 32'h0);
      chk($sformatf("reset_err d%0d", d), 32'(er[d]), 32'd0);
      rstN[d] = 1'b1;
    end
    @(negedge Clk);
    for (int d = 0; d < 3; d++) chk($sformatf("ready_after_reset d%0d", d), 32'(rdy[d]), 32'd1);

    // directed table on instance 0 (read 2, write 1)
    for (int i = 0; i < 11; i++) begin
      transact(0, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].wdt, rdat, err, lat);
      chk($sformatf("tbl%0d_rdata", i), rdat, tbl[i].expRd);
      chk($sformatf("tbl%0d_err", i), 32'(err), 32'(tbl[i].expErr));
      chk($sformatf("tbl%0d_lat", i), 32'(lat), tbl[i].w ? 32'd1 : 32'd2);
    end

    // backpressure: response held for 5 cycles while a new request waits
    @(negedge Clk);
    rv[0] = 1'b1; rw[0] = 1'b0; ra[0] = 32'h20; rs[0] = 2'b00; rr[0] = 1'b0;
    @(negedge Clk);
    ra[0] = 32'h10;
    guard = 0;
    while (vld[0] !== 1'b1 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge Clk);
      chk($sformatf("bp_valid c%0d", i), 32'(vld[0]), 32'd1);
      chk($sformatf("bp_rdata c%0d", i), rd[0], 32'hBEEFAA44);
      chk($sformatf("bp_ready c%0d", i), 32'(rdy[0]), 32'd0);
    end
    rr[0] = 1'b1;
    @(negedge Clk);
    chk("bp_valid_after_hs", 32'(vld[0]), 32'd0);
    chk("bp_ready_after_hs", 32'(rdy[0]), 32'd1);
    @(negedge Clk);
    rv[0] = 1'b0;
    chk("bp_held_accepted", 32'(rdy[0]), 32'd0);
    lat = 1;
    while (vld[0] !== 1'b1 && lat < 100) begin
      @(negedge Clk);
      lat++;
    end
    chk("bp_held_lat", 32'(lat), 32'd2);
    chk("bp_held_rdata", rd[0], 32'hDEADBEEF);
    @(negedge Clk);

    // reset in WAIT on instance 1 (read 4, write 3): store must not land
    runOp(1, 1'b1, 32'h30, 2'b00, 32'h12345678);
    @(negedge Clk);
    rv[1] = 1'b1; rw[1] = 1'b1; ra[1] = 32'h30; rs[1] = 2'b00; wd[1] = 32'h55555555; rr[1] = 1'b1;
    @(negedge Clk);
    rv[1] = 1'b0;
    chk("wait_ready_low", 32'(rdy[1]), 32'd0);
    @(negedge Clk);
    rstN[1] = 1'b0;
    #1;
    chk("rst_wait_valid", 32'(vld[1]), 32'd0);
    chk("rst_wait_ready", 32'(rdy[1]), 32'd0);
    @(negedge Clk);
    @(negedge Clk);
    rstN[1] = 1'b1;
    runOp(1, 1'b0, 32'h30, 2'b00, 32'h0);

    // reset while the response is held: outputs drop asynchronously
    @(negedge Clk);
    rv[1] = 1'b1; rw[1] = 1'b0; ra[1] = 32'h30; rs[1] = 2'b00; rr[1] = 1'b0;
    @(negedge Clk);
    rv[1] = 1'b0;
    guard = 0;
    while (vld[1] !== 1'b1 && guard < 100) begin
      @(negedge Clk);
      guard++;
    end
    chk("resp_before_rst", rd[1], 32'h12345678);
    #2;
    rstN[1] = 1'b0;
    #1;
    chk("rst_resp_valid", 32'(vld[1]), 32'd0);
    chk("rst_resp_rdata", rd[1], 32'h0);
    @(negedge Clk);
    rstN[1] = 1'b1;
    rr[1] = 1'b1;

    // instance 2: latency 1 for both directions
    runOp(2, 1'b1, 32'h8, 2'b00, 32'hCAFEF00D);
    runOp(2, 1'b0, 32'h8, 2'b00, 32'h0);

    // randomized traffic against the reference model
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) runOp(d, 1'b1, 32'h400 + 32'(4 * i), 2'b00, $urandom());
      for (int i = 0; i < 40; i++) begin
        if ($urandom_range(0, 7) == 0) a = $urandom() | 32'h1000;
        else a = 32'h400 + 32'($urandom_range(0, 63));
        runOp(d, 1'($urandom_range(0, 1)), a, 2'($urandom_range(0, 3)), $urandom());
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
